// File: rtl/instr_fetch_controller.sv
// Instruction fetch controller for a combinational program ROM.
// It keeps an internal PC and presents it on mem_address_o in every state.
// The ROM word returned in the same cycle is registered onto instruction_o,
// and its address is registered onto pc_o.
// Halt, branch redirect and stall are supported. Fetching from a PC outside
// the ROM window, or from a misaligned PC, enters a sticky fault.
//
// Ports:
//   clk, reset                        clock, asynchronous active-high reset
//   start_i, halt_i, stall_i          run control
//   branch_valid_i, branch_target_i   redirect request and target byte address
//   mem_address_o, mem_instruction_i  ROM address out, ROM data in
//   instruction_o, pc_o, instr_valid_o  registered fetch result
//   fault_o, fault_addr_o             sticky fault flag and offending PC
//   state_o                           current FSM state
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | not fetching, PC held, waiting for start_i
// S_FETCH | streaming one word per cycle
// S_HOLD  | downstream stalled, outputs and PC frozen
// S_FAULT | illegal PC seen, frozen until reset
module instr_fetch_controller #(
    parameter int unsigned            MEMORY_DEPTH = 256,
    parameter int unsigned            DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0]  BASE_ADDR    = 32'h00400000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  halt_i,
    input  logic                  stall_i,
    input  logic                  branch_valid_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    output logic [DATA_WIDTH-1:0] mem_address_o,
    input  logic [DATA_WIDTH-1:0] mem_instruction_i,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  instr_valid_o,
    output logic                  fault_o,
    output logic [DATA_WIDTH-1:0] fault_addr_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // The bounds are compared one bit wider than the data width, so a window
    // near the top of the address space cannot wrap around.
    localparam logic [DATA_WIDTH:0] FIRST_ADDR = {1'b0, BASE_ADDR};
    localparam logic [DATA_WIDTH:0] LAST_ADDR  =
        FIRST_ADDR + (DATA_WIDTH+1)'(4 * (MEMORY_DEPTH - 1));

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                  valid_q, valid_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic                  pc_legal;

    assign pc_legal = (pc_q[1:0] == 2'b00) &&
                      ({1'b0, pc_q} >= FIRST_ADDR) &&
                      ({1'b0, pc_q} <= LAST_ADDR);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        unique case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH, S_HOLD: begin
                if (halt_i) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end else if (branch_valid_i) begin
                    // The target is only range-checked once it becomes the PC.
                    pc_d    = branch_target_i;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!pc_legal) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    fault_addr_d = pc_q;
                    valid_d      = 1'b0;
                end else if (stall_i) begin
                    state_d = S_HOLD;
                end else begin
                    instr_d  = mem_instruction_i;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + DATA_WIDTH'(4);
                    state_d  = S_FETCH;
                end
            end
            S_FAULT: begin
                valid_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            pc_q         <= BASE_ADDR;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign mem_address_o = pc_q;
    assign instruction_o = instr_q;
    assign pc_o          = pc_out_q;
    assign instr_valid_o = valid_q;
    assign fault_o       = fault_q;
    assign fault_addr_o  = fault_addr_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_instr_fetch_controller.sv
module tb_instr_fetch_controller;

    localparam logic [31:0] BASE  = 32'h00400000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0, halt_i = 1'b0, stall_i = 1'b0, branch_valid_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] mem_address_o, mem_instruction_i, instruction_o, pc_o, fault_addr_o;
    logic        instr_valid_o, fault_o;
    logic [1:0]  state_o;

    instr_fetch_controller #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .halt_i(halt_i), .stall_i(stall_i),
        .branch_valid_i(branch_valid_i), .branch_target_i(branch_target_i),
        .mem_address_o(mem_address_o), .mem_instruction_i(mem_instruction_i),
        .instruction_o(instruction_o), .pc_o(pc_o), .instr_valid_o(instr_valid_o),
        .fault_o(fault_o), .fault_addr_o(fault_addr_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // ROM: word n holds 32'h1000_0000 + n.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h10000000 + ((a - BASE) >> 2);
    endfunction
    assign mem_instruction_i = rom_word(mem_address_o);

    // Reference model, written directly from the fetch rules.
    localparam int M_IDLE = 0, M_FETCH = 1, M_HOLD = 2, M_FAULT = 3;
    int          m_state;
    logic [31:0] m_pc, m_instr, m_pcout, m_faddr;
    logic        m_valid, m_fault;

    function automatic bit legal(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a % 4 == 0) && (off >= 0) && (off / 4 < DEPTH);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = M_IDLE; m_pc = BASE; m_instr = 0; m_pcout = 0;
            m_valid = 0; m_fault = 0; m_faddr = 0;
        end else if (m_state == M_IDLE) begin
            m_valid = 0;
            if (start_i) m_state = M_FETCH;
        end else if (m_state == M_FETCH || m_state == M_HOLD) begin
            if (halt_i) begin
                m_state = M_IDLE; m_valid = 0;
            end else if (branch_valid_i) begin
                m_pc = branch_target_i; m_valid = 0; m_state = M_FETCH;
            end else if (!legal(m_pc)) begin
                m_state = M_FAULT; m_fault = 1; m_faddr = m_pc; m_valid = 0;
            end else if (stall_i) begin
                m_state = M_HOLD;
            end else begin
                m_instr = rom_word(m_pc); m_pcout = m_pc; m_valid = 1;
                m_pc = m_pc + 4; m_state = M_FETCH;
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("state",      {30'd0, state_o}, 32'(m_state));
        chk("mem_addr",   mem_address_o,    m_pc);
        chk("instr",      instruction_o,    m_instr);
        chk("pc_o",       pc_o,             m_pcout);
        chk("valid",      {31'd0, instr_valid_o}, {31'd0, m_valid});
        chk("fault",      {31'd0, fault_o},       {31'd0, m_fault});
        chk("fault_addr", fault_addr_o,     m_faddr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start_i = 0; halt_i = 0; stall_i = 0; branch_valid_i = 0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic start_pulse();
        start_i = 1'b1; tick(); start_i = 1'b0;
    endtask

    logic [31:0] targets [3];

    initial begin
        targets[0] = 32'h00400402;
        targets[1] = 32'h003FFFFC;
        targets[2] = 32'h00400400;

        do_reset();
        chk("lit_reset_state", {30'd0, state_o}, 32'd0);
        chk("lit_reset_addr", mem_address_o, 32'h00400000);

        // First fetch and streaming
        start_pulse();
        tick();
        chk("lit_first_instr", instruction_o, 32'h10000000);
        chk("lit_first_pc", pc_o, 32'h00400000);
        chk("lit_first_valid", {31'd0, instr_valid_o}, 32'd1);
        tick();
        // Stall for 3 cycles
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_stall_state", {30'd0, state_o}, 32'd2);
            chk("lit_stall_pc", pc_o, 32'h00400004);
            chk("lit_stall_addr", mem_address_o, 32'h00400008);
        end
        stall_i = 1'b0;
        tick();
        chk("lit_resume_pc", pc_o, 32'h00400008);
        chk("lit_resume_instr", instruction_o, 32'h10000002);

        // Branch together with stall
        branch_valid_i = 1'b1; branch_target_i = 32'h00400040; stall_i = 1'b1;
        tick();
        branch_valid_i = 1'b0; stall_i = 1'b0;
        chk("lit_branch_addr", mem_address_o, 32'h00400040);
        chk("lit_branch_bubble", {31'd0, instr_valid_o}, 32'd0);
        tick();
        chk("lit_branch_pc", pc_o, 32'h00400040);
        chk("lit_branch_valid", {31'd0, instr_valid_o}, 32'd1);

        // Illegal branch targets
        foreach (targets[k]) begin
            do_reset();
            start_pulse();
            branch_valid_i = 1'b1; branch_target_i = targets[k];
            tick();
            branch_valid_i = 1'b0;
            tick();
            chk("lit_fault_flag", {31'd0, fault_o}, 32'd1);
            chk("lit_fault_addr", fault_addr_o, targets[k]);
            chk("lit_fault_state", {30'd0, state_o}, 32'd3);
            start_i = 1'b1; branch_valid_i = 1'b1; branch_target_i = BASE;
            tick(); tick();
            start_i = 1'b0; branch_valid_i = 1'b0;
            chk("lit_fault_sticky", {30'd0, state_o}, 32'd3);
            chk("lit_fault_addr_sticky", fault_addr_o, targets[k]);
        end

        // Stream to the last word
        do_reset();
        start_pulse();
        repeat (256) tick();
        chk("lit_last_pc", pc_o, 32'h004003FC);
        chk("lit_last_instr", instruction_o, 32'h100000FF);
        chk("lit_last_valid", {31'd0, instr_valid_o}, 32'd1);
        tick();
        chk("lit_end_fault", {31'd0, fault_o}, 32'd1);
        chk("lit_end_fault_addr", fault_addr_o, 32'h00400400);

        // Halt and resume
        do_reset();
        start_pulse();
        repeat (4) tick();
        halt_i = 1'b1; tick(); halt_i = 1'b0;
        chk("lit_halt_state", {30'd0, state_o}, 32'd0);
        chk("lit_halt_addr", mem_address_o, 32'h00400010);
        tick(); tick();
        start_pulse();
        tick();
        chk("lit_resume_halt_pc", pc_o, 32'h00400010);

        // Reset between clock edges
        tick();
        #2 reset = 1'b1;
        #1;
        chk("lit_async_state", {30'd0, state_o}, 32'd0);
        chk("lit_async_addr", mem_address_o, BASE);
        chk("lit_async_instr", instruction_o, 32'd0);
        chk("lit_async_pc", pc_o, 32'd0);
        chk("lit_async_valid", {31'd0, instr_valid_o}, 32'd0);
        tick();
        reset = 1'b0;

        // Randomized run
        for (int c = 0; c < 3000; c++) begin
            start_i        = ($urandom_range(0, 4) == 0);
            halt_i         = ($urandom_range(0, 39) == 0);
            stall_i        = ($urandom_range(0, 3) == 0);
            branch_valid_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 7) == 0)
                branch_target_i = $urandom();
            else
                branch_target_i = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            reset = (m_state == M_FAULT) ? ($urandom_range(0, 9) == 0)
                                         : ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch_controller.md
INSTR_FETCH_CONTROLLER -- requirements
Module: instr_fetch_controller

Interface
REQ-001 SHALL have parameter MEMORY_DEPTH, default 256, meaning program memory depth in 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning address and instruction width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00400000, meaning byte address of program memory word 0.
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port: start_i  input  1  begin or resume fetching from the current PC.
REQ-007 SHALL have port: halt_i  input  1  stop fetching and return to IDLE.
REQ-008 SHALL have port: stall_i  input  1  downstream not ready; hold the current output.
REQ-009 SHALL have port: branch_valid_i  input  1  redirect request.
REQ-010 SHALL have port: branch_target_i  input  DATA_WIDTH  redirect byte address.
REQ-011 SHALL have port: mem_address_o  output  DATA_WIDTH  byte address to the combinational program ROM.
REQ-012 SHALL have port: mem_instruction_i  input  DATA_WIDTH  ROM read data, valid in the same cycle as mem_address_o.
REQ-013 SHALL have port: instruction_o  output  DATA_WIDTH  registered fetched instruction.
REQ-014 SHALL have port: pc_o  output  DATA_WIDTH  registered address of instruction_o.
REQ-015 SHALL have port: instr_valid_o  output  1  instruction_o/pc_o hold a valid fetch.
REQ-016 SHALL have port: fault_o  output  1  sticky fetch fault flag.
REQ-017 SHALL have port: fault_addr_o  output  DATA_WIDTH  offending PC, captured on fault.
REQ-018 SHALL have port: state_o  output  2  current state encoding.

Function
REQ-019 SHALL implement states IDLE=0, FETCH=1, HOLD=2, FAULT=3, driven on state_o.
REQ-020 SHALL hold an internal PC register and drive mem_address_o = PC combinationally in every state.
REQ-021 SHALL treat a PC as legal only if PC[1:0]==0 and BASE_ADDR <= PC <= BASE_ADDR+4*(MEMORY_DEPTH-1), using unsigned compares with no modular wrap.
REQ-022 IDLE: instr_valid_o=0 and PC held; on start_i go to FETCH; halt_i, stall_i and branch_valid_i are ignored.
REQ-023 FETCH and HOLD: each cycle SHALL evaluate, in priority order, halt, branch, fault, stall, then normal operation.
REQ-024 Halt: go to IDLE, instr_valid_o<=0, PC held, so a later start_i resumes at the same PC.
REQ-025 Branch: PC<=branch_target_i, instr_valid_o<=0 (one bubble), go to FETCH; the target is not range-checked until it is the current PC.
REQ-026 Fault (current PC illegal, no halt or branch): go to FAULT, fault_o<=1, fault_addr_o<=PC, instr_valid_o<=0.
REQ-027 Stall: PC, instruction_o, pc_o and instr_valid_o held; go to or stay in HOLD.
REQ-028 Normal operation (FETCH, or HOLD with stall_i deasserted): instruction_o<=mem_instruction_i, pc_o<=PC, instr_valid_o<=1, PC<=PC+4 (32-bit wrap), state FETCH.
REQ-029 Latency SHALL be one cycle: the word at PC=A appears on instruction_o the cycle after A is on mem_address_o.
REQ-030 FAULT SHALL be sticky; all inputs are ignored until reset, instr_valid_o=0, and PC, fault_addr_o and fault_o are held.
REQ-031 Incrementing past the last legal word, including the 32'hFFFFFFFC to 0 wrap, SHALL be detected as a fault on the following cycle.

Reset
REQ-032 Asserting reset SHALL immediately, regardless of clk, set state=IDLE, PC=BASE_ADDR, instruction_o=0, pc_o=0, instr_valid_o=0, fault_o=0, fault_addr_o=0.
REQ-033 Reset asserted mid-fetch, mid-stall or in FAULT SHALL abandon the operation with no partial update after release; fetching restarts only on start_i.

Verification
REQ-034 Reset, then start_i for 1 cycle, with the ROM model holding word n = 32'h1000_0000+n -> mem_address_o 0x00400000, 0x00400004, ...; instruction_o=32'h10000000 with pc_o=0x00400000 and valid one cycle after start.
REQ-035 stall_i high for 3 cycles during streaming -> state_o=2, and instruction_o, pc_o and mem_address_o held for 3 cycles; streaming resumes with no skipped or duplicated word.
REQ-036 branch_valid_i with target 0x00400040 together with stall_i -> next cycle PC=0x00400040 and instr_valid_o=0; the following cycle pc_o=0x00400040 and valid=1.
REQ-037 Branch to 0x00400402 (misaligned), 0x003FFFFC and 0x00400400 (depth 256), each from reset -> fault_o=1, fault_addr_o equal to the target, state_o=3, sticky under start_i and branch_valid_i until reset.
REQ-038 Stream to the last word 0x004003FC -> valid fetch of word 255, then fault with fault_addr_o=0x00400400.
REQ-039 halt_i at PC=0x00400010, then start_i -> next valid fetch has pc_o=0x00400010; reset asserted between clock edges -> all outputs return to their reset values immediately.
